// File: rtl/bitonic_ds_seq.sv
// bitonic_ds_seq: loads a frame of 8 unsigned elements, sorts them in
// descending order with an 8-input bitonic network (one stage per cycle on
// registered storage), then streams the result out largest first.
module bitonic_ds_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] number_in,
  output logic             busy,
  output logic             out_valid,
  output logic [WIDTH-1:0] number_out
);

  typedef enum logic [1:0] {IDLE, LOAD, SORT, OUT} state_t;

  state_t           state_q, state_d;
  // Shared counter: load index in LOAD, stage number in SORT, read index in OUT
  logic [2:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q [8];
  logic [WIDTH-1:0] data_d [8];
  logic [WIDTH-1:0] stageOut [8];
  logic             busy_q, busy_d;
  logic             outValid_q, outValid_d;
  logic [WIDTH-1:0] numberOut_q, numberOut_d;
  logic [3:0]       kSel;
  logic [2:0]       jSel;

  assign busy       = busy_q;
  assign out_valid  = outValid_q;
  assign number_out = numberOut_q;

  // Select the (k,j) parameters of the network stage applied this cycle
  always_comb begin
    kSel = 4'd8;
    jSel = 3'd1;
    case (cnt_q)
      3'd0:    begin kSel = 4'd2; jSel = 3'd1; end
      3'd1:    begin kSel = 4'd4; jSel = 3'd2; end
      3'd2:    begin kSel = 4'd4; jSel = 3'd1; end
      3'd3:    begin kSel = 4'd8; jSel = 3'd4; end
      3'd4:    begin kSel = 4'd8; jSel = 3'd2; end
      default: begin kSel = 4'd8; jSel = 3'd1; end
    endcase
  end

  // One bitonic stage: compare-exchange all four (i, i^j) pairs in parallel
  always_comb begin : stageNet
    logic [2:0] lo;
    logic [2:0] hi;
    lo = '0;
    hi = '0;
    for (int i = 0; i < 8; i++) begin
      stageOut[i] = data_q[i];
    end
    for (int i = 0; i < 8; i++) begin
      lo = 3'(i);
      hi = lo ^ jSel;
      if (hi > lo) begin
        if (({1'b0, lo} & kSel) == 4'd0) begin
          if (data_q[hi] > data_q[lo]) begin
            stageOut[lo] = data_q[hi];
            stageOut[hi] = data_q[lo];
          end
        end else begin
          if (data_q[hi] < data_q[lo]) begin
            stageOut[lo] = data_q[hi];
            stageOut[hi] = data_q[lo];
          end
        end
      end
    end
  end

  // Next-state, storage update and registered-output values for each phase
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    outValid_d  = 1'b0;
    numberOut_d = '0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d[0] = number_in;
          cnt_d     = 3'd1;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        if (in_valid) begin
          data_d[cnt_q] = number_in;
          if (cnt_q == 3'd7) begin
            cnt_d   = 3'd0;
            state_d = SORT;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      SORT: begin
        data_d = stageOut;
        if (cnt_q == 3'd5) begin
          cnt_d   = 3'd0;
          state_d = OUT;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      OUT: begin
        outValid_d  = 1'b1;
        numberOut_d = data_q[cnt_q];
        if (cnt_q == 3'd7) begin
          cnt_d   = 3'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    endcase
    busy_d = (state_d == SORT) || (state_d == OUT);
  end

  // Control and output registers; reset wins over any input activity
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      busy_q      <= 1'b0;
      outValid_q  <= 1'b0;
      numberOut_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      outValid_q  <= outValid_d;
      numberOut_q <= numberOut_d;
    end
  end

  // Element storage needs no reset: it is always fully rewritten before use
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

endmodule

// File: tb/tb_bitonic_ds_seq.sv
// tb_bitonic_ds_seq: scenario tasks for bitonic_ds_seq, checked against a
// plain descending sort of each loaded frame.
module tb_bitonic_ds_seq;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [7:0] number_in;
  logic       busy;
  logic       out_valid;
  logic [7:0] number_out;

  int checks;
  int errors;

  logic [7:0] frame    [8];
  logic [7:0] expected [8];
  logic [7:0] got      [8];

  bitonic_ds_seq #(.WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .number_in  (number_in),
    .busy       (busy),
    .out_valid  (out_valid),
    .number_out (number_out)
  );

  // Free-running clock, 10 time units per period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: the frame sorted largest first
  task automatic computeExpected();
    logic [7:0] tmp;
    for (int i = 0; i < 8; i++) expected[i] = frame[i];
    for (int i = 0; i < 8; i++) begin
      for (int j = i + 1; j < 8; j++) begin
        if (expected[j] > expected[i]) begin
          tmp = expected[i];
          expected[i] = expected[j];
          expected[j] = tmp;
        end
      end
    end
  endtask

  // Drive one frame; gapMode 0 = back-to-back, 1 = idle cycle between
  // elements, 2 = random idle cycles. Returns #1 after the edge storing element 7.
  task automatic sendFrame(input int gapMode);
    for (int i = 0; i < 8; i++) begin
      if (i > 0 && (gapMode == 1 || (gapMode == 2 && $urandom_range(0, 1) == 1))) begin
        in_valid  = 1'b0;
        number_in = 8'hEE;
        @(posedge clk); #1;
      end
      in_valid  = 1'b1;
      number_in = frame[i];
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    number_in = 8'h00;
  endtask

  // Record the output stream; sample c is taken #1 after edge t+c. Stops on
  // the first idle sample after outputs began, or after a bounded cycle budget.
  task automatic collect(input bit junk, output int lat, output int busyCnt,
                         output int n, output logic [7:0] tailNum);
    lat = -1; busyCnt = 0; n = 0; tailNum = 8'hxx;
    for (int c = 0; c < 40; c++) begin
      if (busy) busyCnt++;
      if (out_valid) begin
        if (lat < 0) lat = c;
        if (n < 8) got[n] = number_out;
        n++;
      end else if (n > 0) begin
        tailNum = number_out;
        break;
      end
      if (junk) begin
        in_valid  = busy;
        number_in = 8'hEE;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; number_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset.busy got %0b expected 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset.out_valid got %0b expected 0", out_valid); end
    checks++; if (number_out !== 8'h00) begin errors++; $display("[TB] FAIL reset.number_out got %0d expected 0", number_out); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat, bc, n;
    logic [7:0] tail;
    frame    = '{8'd3, 8'd7, 8'd1, 8'd9, 8'd0, 8'd255, 8'd128, 8'd7};
    expected = '{8'd255, 8'd128, 8'd9, 8'd7, 8'd7, 8'd3, 8'd1, 8'd0};
    sendFrame(0);
    collect(1'b0, lat, bc, n, tail);
    checks++; if (n != 8) begin errors++; $display("[TB] FAIL basic.count got %0d expected 8", n); end
    checks++; if (lat != 7) begin errors++; $display("[TB] FAIL basic.latency got %0d expected 7", lat); end
    checks++; if (bc != 14) begin errors++; $display("[TB] FAIL basic.busy_cycles got %0d expected 14", bc); end
    checks++; if (tail !== 8'h00) begin errors++; $display("[TB] FAIL basic.tail_number got %0d expected 0", tail); end
    for (int m = 0; m < 8; m++) begin
      checks++;
      if (got[m] !== expected[m]) begin errors++; $display("[TB] FAIL basic.out[%0d] got %0d expected %0d", m, got[m], expected[m]); end
    end
  endtask

  task automatic test_stall();
    int lat, bc, n;
    logic [7:0] tail;
    for (int i = 0; i < 8; i++) frame[i] = 8'(i + 1);
    computeExpected();
    sendFrame(1);
    collect(1'b0, lat, bc, n, tail);
    checks++; if (n != 8) begin errors++; $display("[TB] FAIL stall.count got %0d expected 8", n); end
    checks++; if (lat != 7) begin errors++; $display("[TB] FAIL stall.latency got %0d expected 7", lat); end
    for (int m = 0; m < 8; m++) begin
      checks++;
      if (got[m] !== expected[m]) begin errors++; $display("[TB] FAIL stall.out[%0d] got %0d expected %0d", m, got[m], expected[m]); end
    end
  endtask

  task automatic test_equal();
    int lat, bc, n;
    logic [7:0] tail;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 8; i++) frame[i] = (f == 0) ? 8'hAA : ((i % 2 == 0) ? 8'hFF : 8'h00);
      computeExpected();
      sendFrame(0);
      collect(1'b0, lat, bc, n, tail);
      checks++; if (n != 8) begin errors++; $display("[TB] FAIL equal%0d.count got %0d expected 8", f, n); end
      for (int m = 0; m < 8; m++) begin
        checks++;
        if (got[m] !== expected[m]) begin errors++; $display("[TB] FAIL equal%0d.out[%0d] got %0d expected %0d", f, m, got[m], expected[m]); end
      end
    end
  endtask

  task automatic test_abort_load();
    int lat, bc, n;
    logic [7:0] tail;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; number_in = 8'(200 + i);
      @(posedge clk); #1;
    end
    reset = 1'b1; in_valid = 1'b1; number_in = 8'hEE;
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_load.busy got %0b expected 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL abort_load.out_valid got %0b expected 0", out_valid); end
    for (int i = 0; i < 8; i++) frame[i] = 8'(10 * (i + 1));
    computeExpected();
    sendFrame(0);
    collect(1'b0, lat, bc, n, tail);
    checks++; if (n != 8) begin errors++; $display("[TB] FAIL abort_load.count got %0d expected 8", n); end
    checks++; if (lat != 7) begin errors++; $display("[TB] FAIL abort_load.latency got %0d expected 7", lat); end
    for (int m = 0; m < 8; m++) begin
      checks++;
      if (got[m] !== expected[m]) begin errors++; $display("[TB] FAIL abort_load.out[%0d] got %0d expected %0d", m, got[m], expected[m]); end
    end
  endtask

  task automatic test_abort_busy();
    int waitCnt, stray;
    // Abort during SORT, then during OUT
    for (int phase = 0; phase < 2; phase++) begin
      for (int i = 0; i < 8; i++) frame[i] = 8'($urandom_range(0, 255));
      sendFrame(0);
      if (phase == 0) begin
        repeat (3) begin @(posedge clk); #1; end
      end else begin
        waitCnt = 0;
        while (out_valid !== 1'b1 && waitCnt < 20) begin
          @(posedge clk); #1; waitCnt++;
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL abort_out.wait got timeout after %0d cycles expected out_valid", waitCnt); end
        repeat (2) begin @(posedge clk); #1; end
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checks++; if (number_out !== 8'h00) begin errors++; $display("[TB] FAIL abort_busy%0d.number_out got %0d expected 0", phase, number_out); end
      stray = 0;
      for (int c = 0; c < 20; c++) begin
        if (out_valid !== 1'b0 || busy !== 1'b0) stray++;
        @(posedge clk); #1;
      end
      checks++; if (stray != 0) begin errors++; $display("[TB] FAIL abort_busy%0d.stray_cycles got %0d expected 0", phase, stray); end
    end
  endtask

  task automatic test_ignore();
    int lat, bc, n, stray;
    logic [7:0] tail;
    frame = '{8'd3, 8'd7, 8'd1, 8'd9, 8'd0, 8'd255, 8'd128, 8'd7};
    computeExpected();
    sendFrame(0);
    collect(1'b1, lat, bc, n, tail);
    checks++; if (n != 8) begin errors++; $display("[TB] FAIL ignore.count got %0d expected 8", n); end
    checks++; if (bc != 14) begin errors++; $display("[TB] FAIL ignore.busy_cycles got %0d expected 14", bc); end
    for (int m = 0; m < 8; m++) begin
      checks++;
      if (got[m] !== expected[m]) begin errors++; $display("[TB] FAIL ignore.out[%0d] got %0d expected %0d", m, got[m], expected[m]); end
    end
    stray = 0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid !== 1'b0 || busy !== 1'b0) stray++;
      @(posedge clk); #1;
    end
    checks++; if (stray != 0) begin errors++; $display("[TB] FAIL ignore.stray_cycles got %0d expected 0", stray); end
  endtask

  task automatic test_back_to_back();
    int lat, bc, n;
    logic [7:0] tail;
    frame = '{8'd3, 8'd7, 8'd1, 8'd9, 8'd0, 8'd255, 8'd128, 8'd7};
    computeExpected();
    sendFrame(0);
    collect(1'b0, lat, bc, n, tail);
    checks++; if (n != 8) begin errors++; $display("[TB] FAIL b2b1.count got %0d expected 8", n); end
    for (int m = 0; m < 8; m++) begin
      checks++;
      if (got[m] !== expected[m]) begin errors++; $display("[TB] FAIL b2b1.out[%0d] got %0d expected %0d", m, got[m], expected[m]); end
    end
    for (int i = 0; i < 8; i++) frame[i] = 8'(9 - i);
    computeExpected();
    sendFrame(0);
    collect(1'b0, lat, bc, n, tail);
    checks++; if (n != 8) begin errors++; $display("[TB] FAIL b2b2.count got %0d expected 8", n); end
    checks++; if (lat != 7) begin errors++; $display("[TB] FAIL b2b2.latency got %0d expected 7", lat); end
    for (int m = 0; m < 8; m++) begin
      checks++;
      if (got[m] !== expected[m]) begin errors++; $display("[TB] FAIL b2b2.out[%0d] got %0d expected %0d", m, got[m], expected[m]); end
    end
  endtask

  task automatic test_random();
    int lat, bc, n;
    logic [7:0] tail;
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < 8; i++)
        frame[i] = (f % 2 == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 3));
      computeExpected();
      sendFrame(2);
      collect(1'b0, lat, bc, n, tail);
      checks++; if (n != 8) begin errors++; $display("[TB] FAIL random%0d.count got %0d expected 8", f, n); end
      checks++; if (lat != 7) begin errors++; $display("[TB] FAIL random%0d.latency got %0d expected 7", f, lat); end
      for (int m = 0; m < 8; m++) begin
        checks++;
        if (got[m] !== expected[m]) begin errors++; $display("[TB] FAIL random%0d.out[%0d] got %0d expected %0d", f, m, got[m], expected[m]); end
      end
    end
  endtask

  // Run every scenario in order, then report
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_stall();
    test_equal();
    test_abort_load();
    test_abort_busy();
    test_ignore();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bitonic_ds_seq.md
BITONIC_DS_SEQ -- requirements
Module: bitonic_ds_seq

Interface
REQ-001 Parameter WIDTH, default 8: bit width of each data element.
REQ-002 clk  input  1: single clock; all state updates on rising edge.
REQ-003 reset  input  1: synchronous, active-high reset, sampled on rising clk.
REQ-004 in_valid  input  1: number_in carries a valid element this cycle.
REQ-005 number_in  input  WIDTH: unsigned element to load.
REQ-006 busy  output  1: high while sorting or streaming out; inputs ignored.
REQ-007 out_valid  output  1: number_out carries a valid sorted element this cycle.
REQ-008 number_out  output  WIDTH: unsigned sorted element, largest first.

Function
REQ-009 The block SHALL sort a frame of exactly 8 unsigned elements into descending order using an 8-input bitonic network.
REQ-010 The FSM SHALL have states IDLE, LOAD, SORT, OUT, with IDLE as the reset state.
REQ-011 IDLE -> LOAD on a cycle with in_valid=1; that element SHALL be stored as element 0.
REQ-012 In LOAD, each cycle with in_valid=1 SHALL store the next element at index 1..7 in arrival order; in_valid=0 SHALL stall with no store and no timeout.
REQ-013 LOAD -> SORT on the cycle that stores element 7.
REQ-014 SORT SHALL last exactly 6 cycles, one network stage per cycle, with stage parameters (k,j) = (2,1),(4,2),(4,1),(8,4),(8,2),(8,1).
REQ-015 Each stage SHALL compare-exchange every pair (i, i^j) with i<i^j, all 4 pairs in parallel, using registered storage.
REQ-016 Pair ordering: if (i&k)==0, the larger value goes to index i; otherwise the smaller goes to index i. Equal values are not swapped.
REQ-017 Comparisons SHALL be unsigned over the full WIDTH.
REQ-018 SORT -> OUT after the 6th stage.
REQ-019 OUT SHALL last 8 cycles; out_valid=1 and number_out = sorted element m (m=0..7, index 0 = largest) in the m-th OUT cycle.
REQ-020 OUT -> IDLE after element 7; out_valid=0 and number_out=0 in the following cycle.
REQ-021 Latency: if element 7 is stored at edge t, the first out_valid=1 SHALL be visible after edge t+7 (6 SORT cycles plus 1 output register).
REQ-022 busy SHALL be 1 in SORT and OUT and 0 in IDLE and LOAD.
REQ-023 in_valid during SORT or OUT SHALL be ignored, with no store and no effect on the current frame.
REQ-024 A new frame MAY start in IDLE on the cycle immediately after the last OUT cycle.
REQ-025 out_valid, number_out and busy SHALL be driven from registers (no combinational input-to-output path).
REQ-026 Outside OUT, out_valid SHALL be 0 and number_out SHALL be 0.

Reset
REQ-027 In reset, the state SHALL go to IDLE and the load index to 0; out_valid=0, busy=0, number_out=0.
REQ-028 Reset asserted in any state (including mid-LOAD, mid-SORT or mid-OUT) SHALL abort the frame, discard partial data and emit no further out_valid pulses.
REQ-029 Reset SHALL take priority over in_valid in the same cycle.
REQ-030 Element storage contents after reset are don't-care; they SHALL never be observable before a full 8-element load.

Verification
REQ-031 Load 3,7,1,9,0,255,128,7 on 8 consecutive cycles -> 7 cycles later, 8 consecutive out_valid cycles with number_out 255,128,9,7,7,3,1,0; busy high for 14 cycles.
REQ-032 Load 1..8 ascending with in_valid low on every other cycle -> output 8,7,6,5,4,3,2,1; no store on idle cycles.
REQ-033 All 8 elements = 0xAA -> output eight times 0xAA; then all-0xFF/0x00 alternating -> output 0xFF x4, then 0x00 x4.
REQ-034 Assert reset after 5 loads, then load 10,20,30,40,50,60,70,80 -> output 80,70,60,50,40,30,20,10 only, with no trace of the aborted data.
REQ-035 Drive in_valid=1 with value 0xEE throughout SORT and OUT of frame 3,7,1,9,0,255,128,7 -> output unchanged from REQ-031; the next frame starts only after return to IDLE.
REQ-036 Back-to-back frames: start frame 2 (9,8,...,2) in the cycle after frame 1's last out_valid -> both frames are sorted correctly.
